// File: rtl/calc1_port_responder_if.sv
// calc1 request/response port: requester drives cmd/data, responder returns
// a response code, result data, busy and a sticky protocol-error flag.
// Bit 0 is the MSB of every vector, matching the calc1 port definition.
interface calc1_port_responder_if;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;
  logic        proto_err;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_resp, out_data, busy, proto_err
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_resp, out_data, busy, proto_err
  );
endinterface

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: takes cmd+operand1, then operand2, runs
// add/sub/shl/shr and returns a one-cycle response RESP_DELAY cycles later.
module calc1_port_responder #(
  parameter int RESP_DELAY = 0  // 0..3 extra cycles before the response
) (
  input logic                     c_clk,
  input logic                     reset,
  calc1_port_responder_if.slave   port
);

  typedef enum logic [1:0] {IDLE, OP2, PIPE, RESP} state_t;

  localparam logic [1:0] LAST_CNT = 2'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        perr_q, perr_d;

  logic [32:0] sum;
  logic [1:0]  alu_resp;
  logic [31:0] alu_data;
  logic        cmd_valid;

  // Internal vectors are [31:0]; assignment to/from the [0:31] port keeps the MSB on the left.
  assign cmd_valid = (port.req_cmd_in != 4'd0);
  assign sum       = {1'b0, op1_q} + {1'b0, op2_q};

  // Result of the latched request; only consumed on the edge leaving RESP.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    alu_resp = RESP_ERR;
    alu_data = 32'd0;
    case (cmd_q)
      4'd1: if (!sum[32]) begin
        alu_resp = RESP_OK;
        alu_data = sum[31:0];
      end
      4'd2: if (op2_q <= op1_q) begin
        alu_resp = RESP_OK;
        alu_data = op1_q - op2_q;
      end
      4'd5: begin
        alu_resp = RESP_OK;
        alu_data = op1_q << op2_q[4:0];
      end
      4'd6: begin
        alu_resp = RESP_OK;
        alu_data = op1_q >> op2_q[4:0];
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic; the response lives one cycle because resp_d defaults to 0.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt_d   = cnt_q;
    resp_d  = RESP_NONE;
    data_d  = 32'd0;
    busy_d  = busy_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        cmd_d   = port.req_cmd_in;
        op1_d   = port.req_data_in;
        busy_d  = 1'b1;
        state_d = OP2;
      end
      OP2: begin
        op2_d   = port.req_data_in;
        cnt_d   = 2'd0;
        perr_d  = perr_q | cmd_valid;
        state_d = (RESP_DELAY > 0) ? PIPE : RESP;
      end
      PIPE: begin
        perr_d = perr_q | cmd_valid;
        if (cnt_q == LAST_CNT) state_d = RESP;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      RESP: begin
        perr_d  = perr_q | cmd_valid;
        resp_d  = alu_resp;
        data_d  = alu_data;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset overrides every input.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q <= IDLE;
      cmd_q   <= 4'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      cnt_q   <= 2'd0;
      resp_q  <= RESP_NONE;
      data_q  <= 32'd0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  assign port.out_resp  = resp_q;
  assign port.out_data  = data_q;
  assign port.busy      = busy_q;
  assign port.proto_err = perr_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed bench for calc1_port_responder: one instance with RESP_DELAY=0,
// one with RESP_DELAY=3. Inputs change #1 after the rising edge and outputs
// are checked at that same point, so each check sees the state after an edge.
module tb_calc1_port_responder;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  calc1_port_responder_if a_if ();
  calc1_port_responder_if b_if ();

  calc1_port_responder #(.RESP_DELAY(0)) dut_a (.c_clk(clk), .reset(reset), .port(a_if));
  calc1_port_responder #(.RESP_DELAY(3)) dut_b (.c_clk(clk), .reset(reset), .port(b_if));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request on the RESP_DELAY=0 instance: E0, E1, response at E2, cleared at E3.
  task automatic do_op(input string tag, input logic [3:0] cmd, input logic [31:0] op1,
                       input logic [31:0] op2, input logic [1:0] er, input logic [31:0] ed);
    a_if.req_cmd_in  = cmd;
    a_if.req_data_in = op1;
    tick();
    check({tag, ".e0_busy"}, a_if.busy, 1);
    check({tag, ".e0_resp"}, a_if.out_resp, 0);
    a_if.req_cmd_in  = 4'd0;
    a_if.req_data_in = op2;
    tick();
    check({tag, ".e1_busy"}, a_if.busy, 1);
    check({tag, ".e1_resp"}, a_if.out_resp, 0);
    a_if.req_data_in = 32'd0;
    tick();
    check({tag, ".e2_resp"}, a_if.out_resp, er);
    check({tag, ".e2_data"}, a_if.out_data, ed);
    check({tag, ".e2_busy"}, a_if.busy, 0);
    tick();
    check({tag, ".e3_resp"}, a_if.out_resp, 0);
    check({tag, ".e3_data"}, a_if.out_data, 0);
  endtask

  initial begin
    reset = 1'b1;
    a_if.req_cmd_in = 4'd0; a_if.req_data_in = 32'd0;
    b_if.req_cmd_in = 4'd0; b_if.req_data_in = 32'd0;
    tick();
    tick();
    check("rst.a_resp", a_if.out_resp, 0);
    check("rst.a_data", a_if.out_data, 0);
    check("rst.a_busy", a_if.busy, 0);
    check("rst.a_perr", a_if.proto_err, 0);
    check("rst.b_resp", b_if.out_resp, 0);
    check("rst.b_busy", b_if.busy, 0);
    reset = 1'b0;
    tick();
    check("idle.a_busy", a_if.busy, 0);

    // Arithmetic and boundaries
    do_op("add_basic", 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000);
    do_op("add_ovf",   4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
    do_op("add_zero",  4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0);
    do_op("add_max",   4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF);
    do_op("sub_under", 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0);
    do_op("sub_eq",    4'd2, 32'h0000_000F, 32'h0000_000F, 2'd1, 32'h0);
    do_op("sub_basic", 4'd2, 32'h0000_1000, 32'h0000_0001, 2'd1, 32'h0000_0FFF);
    for (int k = 0; k <= 30; k++) begin
      do_op($sformatf("shl_k%0d", k), 4'd5, 32'd1 << k, 32'd1, 2'd1, 32'd1 << (k + 1));
    end
    do_op("shl_out",   4'd5, 32'h8000_0000, 32'h0000_0001, 2'd1, 32'h0);
    do_op("shl_zero",  4'd5, 32'h1234_5678, 32'h0000_0000, 2'd1, 32'h1234_5678);
    do_op("shr_wrap",  4'd6, 32'h8000_0000, 32'h0000_0021, 2'd1, 32'h4000_0000);
    do_op("shr_basic", 4'd6, 32'hF000_000F, 32'h0000_0004, 2'd1, 32'h0F00_0000);
    do_op("inv_cmd3",  4'd3, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'h0);
    do_op("inv_cmd4",  4'd4, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'h0);
    do_op("inv_cmd15", 4'd15, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'h0);
    check("perr_clean", a_if.proto_err, 0);

    // Back-to-back: new cmd presented during the response cycle
    a_if.req_cmd_in = 4'd1; a_if.req_data_in = 32'd3;
    tick();
    a_if.req_cmd_in = 4'd0; a_if.req_data_in = 32'd4;
    tick();
    a_if.req_data_in = 32'd0;
    tick();
    check("b2b.first_resp", a_if.out_resp, 1);
    check("b2b.first_data", a_if.out_data, 7);
    a_if.req_cmd_in = 4'd1; a_if.req_data_in = 32'd10;
    tick();
    check("b2b.accept_busy", a_if.busy, 1);
    check("b2b.accept_resp", a_if.out_resp, 0);
    a_if.req_cmd_in = 4'd0; a_if.req_data_in = 32'd20;
    tick();
    a_if.req_data_in = 32'd0;
    tick();
    check("b2b.second_resp", a_if.out_resp, 1);
    check("b2b.second_data", a_if.out_data, 30);
    check("b2b.perr", a_if.proto_err, 0);
    tick();

    // RESP_DELAY=3: add 5+7 appears at E5
    b_if.req_cmd_in = 4'd1; b_if.req_data_in = 32'd5;
    tick();
    check("d3.e0_busy", b_if.busy, 1);
    b_if.req_cmd_in = 4'd0; b_if.req_data_in = 32'd7;
    tick();
    b_if.req_data_in = 32'd0;
    for (int e = 2; e <= 4; e++) begin
      tick();
      check($sformatf("d3.e%0d_resp", e), b_if.out_resp, 0);
      check($sformatf("d3.e%0d_busy", e), b_if.busy, 1);
    end
    tick();
    check("d3.e5_resp", b_if.out_resp, 1);
    check("d3.e5_data", b_if.out_data, 12);
    check("d3.e5_busy", b_if.busy, 0);
    tick();
    check("d3.e6_resp", b_if.out_resp, 0);

    // Protocol error: nonzero cmd in the operand2 cycle
    a_if.req_cmd_in = 4'd1; a_if.req_data_in = 32'd5;
    tick();
    a_if.req_cmd_in = 4'd2; a_if.req_data_in = 32'd3;
    tick();
    check("perr.set", a_if.proto_err, 1);
    a_if.req_cmd_in = 4'd0; a_if.req_data_in = 32'd0;
    tick();
    check("perr.resp", a_if.out_resp, 1);
    check("perr.data", a_if.out_data, 8);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("perr.no_second_resp%0d", i), a_if.out_resp, 0);
      check($sformatf("perr.no_second_busy%0d", i), a_if.busy, 0);
    end
    check("perr.sticky", a_if.proto_err, 1);

    // Reset at E1 aborts the request
    a_if.req_cmd_in = 4'd1; a_if.req_data_in = 32'd1;
    tick();
    check("rst_mid.e0_busy", a_if.busy, 1);
    reset = 1'b1;
    a_if.req_cmd_in = 4'd0; a_if.req_data_in = 32'd2;
    tick();
    check("rst_mid.busy", a_if.busy, 0);
    check("rst_mid.resp", a_if.out_resp, 0);
    check("rst_mid.perr", a_if.proto_err, 0);
    reset = 1'b0;
    a_if.req_data_in = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_mid.no_resp%0d", i), a_if.out_resp, 0);
      check($sformatf("rst_mid.no_busy%0d", i), a_if.busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
